// File: rtl/axi_master_rd.sv
// AXI4 read master: one user request becomes one AR burst, and R beats stream straight through to the user.
// AR is issued 1 cycle after accept; R is combinational pass-through, and user rd_data_ready stalls rready.
module axi_master_rd #(
  parameter int ADDR_WIDTH = 30,
  parameter int DATA_WIDTH = 64,
  parameter int ID_WIDTH   = 4,
  parameter int AXI_ID     = 0
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  rd_start,
  input  logic [ADDR_WIDTH-1:0] rd_addr,
  input  logic [7:0]            rd_len,
  output logic                  rd_req_ready,
  output logic [DATA_WIDTH-1:0] rd_data,
  output logic                  rd_data_valid,
  input  logic                  rd_data_ready,
  output logic                  rd_data_last,
  output logic                  rd_done,
  output logic                  rd_err,
  output logic [ID_WIDTH-1:0]   m_axi_arid,
  output logic [ADDR_WIDTH-1:0] m_axi_araddr,
  output logic [7:0]            m_axi_arlen,
  output logic [2:0]            m_axi_arsize,
  output logic [1:0]            m_axi_arburst,
  output logic                  m_axi_arlock,
  output logic [3:0]            m_axi_arcache,
  output logic [2:0]            m_axi_arprot,
  output logic [3:0]            m_axi_arqos,
  output logic                  m_axi_arvalid,
  input  logic                  m_axi_arready,
  input  logic [DATA_WIDTH-1:0] m_axi_rdata,
  input  logic [1:0]            m_axi_rresp,
  input  logic                  m_axi_rlast,
  input  logic                  m_axi_rvalid,
  output logic                  m_axi_rready
);

  localparam logic [2:0] LP_SIZE = 3'($clog2(DATA_WIDTH / 8));

  typedef enum logic [1:0] {S_IDLE, S_AR, S_R, S_DONE} state_t;

  state_t                r_state;
  state_t                w_state_nxt;
  logic [ADDR_WIDTH-1:0] r_addr;
  logic [7:0]            r_len;
  logic [7:0]            r_cnt;
  logic                  r_err;
  logic                  r_arvalid;
  logic                  w_in_r;
  logic                  w_rhs;
  logic                  w_cnt_last;
  logic                  w_beat_err;

  assign w_in_r     = (r_state == S_R);
  assign w_rhs      = w_in_r & m_axi_rvalid & rd_data_ready;
  assign w_cnt_last = (r_cnt == r_len);
  // RLAST is only checked against our own count; the count alone ends the burst.
  assign w_beat_err = (m_axi_rresp != 2'b00) | (m_axi_rlast != w_cnt_last);

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:  if (rd_start) w_state_nxt = S_AR;
      S_AR:    if (r_arvalid & m_axi_arready) w_state_nxt = S_R;
      S_R:     if (w_rhs & w_cnt_last) w_state_nxt = S_DONE;
      S_DONE:  w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state   <= S_IDLE;
      r_addr    <= '0;
      r_len     <= '0;
      r_cnt     <= '0;
      r_err     <= 1'b0;
      r_arvalid <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      if ((r_state == S_IDLE) && rd_start) begin
        r_addr    <= rd_addr;
        r_len     <= rd_len;
        r_cnt     <= '0;
        r_err     <= 1'b0;
        r_arvalid <= 1'b1;
      end
      if ((r_state == S_AR) && r_arvalid && m_axi_arready) begin
        r_arvalid <= 1'b0;
      end
      if (w_rhs) begin
        r_cnt <= r_cnt + 8'd1;
        if (w_beat_err) r_err <= 1'b1;
      end
    end
  end

  assign rd_req_ready  = (r_state == S_IDLE);
  assign rd_data       = m_axi_rdata;
  assign rd_data_valid = w_in_r & m_axi_rvalid;
  assign rd_data_last  = rd_data_valid & w_cnt_last;
  assign rd_done       = (r_state == S_DONE);
  assign rd_err        = (r_state == S_DONE) & r_err;

  assign m_axi_arid    = ID_WIDTH'(AXI_ID);
  assign m_axi_araddr  = r_addr;
  assign m_axi_arlen   = r_len;
  assign m_axi_arsize  = LP_SIZE;
  assign m_axi_arburst = 2'b01;
  assign m_axi_arlock  = 1'b0;
  assign m_axi_arcache = 4'b0010;
  assign m_axi_arprot  = 3'b000;
  assign m_axi_arqos   = 4'b0000;
  assign m_axi_arvalid = r_arvalid;
  assign m_axi_rready  = w_in_r & rd_data_ready;

endmodule
